lms_sequencer: RTL

- Time-multiplexed LMS adaptive FIR engine built around one shared signed multiplier.
- Per accepted sample it performs three steps:
  - shifts the sample into the internal delay line;
  - computes the filter output serially, one tap per cycle;
  - forms the error and applies the weight update serially, one tap per cycle.
- Sits between the sample source and the downstream error/output consumer. It replaces the fully parallel per-tap weight update, which costs TAPS multipliers.

---
 rtl/lms_pkg.sv | 39 +++
 rtl/lms_sat_mul.sv | 27 ++
 rtl/lms_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/lms_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lms_pkg                                                              |
// | Shared types and fixed-point helpers for the LMS sequencer.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lms_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC  = 3'd1,
        ERR  = 3'd2,
        UPD  = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Wide intermediate used by all saturating casts.
    localparam int c_wide_w = 64;

    function automatic int frac_bits(input int width);
        return width - 1;
    endfunction

    function automatic int acc_width(input int width, input int taps);
        return 2 * width + $clog2(taps);
    endfunction

    // Clamp to the signed range of 'width' bits; callers size-cast the result.
    function automatic logic signed [c_wide_w-1:0] sat(input logic signed [c_wide_w-1:0] v,
                                                       input int width);
        logic signed [c_wide_w-1:0] hi;
        logic signed [c_wide_w-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lms_sat_mul.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lms_sat_mul                                                          |
// | Shared signed multiplier with raw, scaled and double-scaled outputs. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lms_sat_mul
    import lms_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] product,
    output logic signed [WIDTH-1:0]   product_q,
    output logic signed [WIDTH+1:0]   product_q2
);

    localparam int c_frac = frac_bits(WIDTH);

    assign product    = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    assign product_q  = WIDTH'(sat(64'(product) >>> c_frac, WIDTH));
    // (2*a*b) >>> frac, left unsaturated so the weight add can saturate once.
    assign product_q2 = (WIDTH+2)'(product >>> (c_frac - 1));

endmodule
`default_nettype wire

// File: rtl/lms_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lms_sequencer                                                        |
// | Time-multiplexed LMS adaptive FIR around one shared multiplier.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lms_sequencer
    import lms_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAPS  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            din,
    input  logic [WIDTH-1:0]            desired,
    input  logic                        adapt_en,
    input  logic [WIDTH-1:0]            step_size,
    input  logic                        clear_weights,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            y_out,
    output logic [WIDTH-1:0]            err_out,
    output logic [TAPS-1:0][WIDTH-1:0]  weights
);

    localparam int c_frac  = frac_bits(WIDTH);
    localparam int c_acc_w = acc_width(WIDTH, TAPS);
    localparam int c_idx_w = $clog2(TAPS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(TAPS - 1);

    state_t                     r_state;
    state_t                     w_next;
    logic signed [WIDTH-1:0]    r_x [TAPS];
    logic signed [WIDTH-1:0]    r_w [TAPS];
    logic signed [c_acc_w-1:0]  r_acc;
    logic [c_idx_w-1:0]         r_idx;
    logic signed [WIDTH-1:0]    r_d;
    logic                       r_adapt;
    logic signed [WIDTH-1:0]    r_mu_e;
    logic signed [WIDTH-1:0]    r_y;
    logic signed [WIDTH-1:0]    r_err;

    logic signed [WIDTH-1:0]    w_a;
    logic signed [WIDTH-1:0]    w_b;
    logic signed [2*WIDTH-1:0]  w_prod;
    logic signed [WIDTH-1:0]    w_prod_q;
    logic signed [WIDTH+1:0]    w_prod_q2;
    logic signed [WIDTH-1:0]    w_y;
    logic signed [WIDTH-1:0]    w_e;
    logic signed [WIDTH-1:0]    w_upd;

    lms_sat_mul #(.WIDTH(WIDTH)) u_mul (
        .a          (w_a),
        .b          (w_b),
        .product    (w_prod),
        .product_q  (w_prod_q),
        .product_q2 (w_prod_q2)
    );

    assign w_y   = WIDTH'(sat(64'(r_acc >>> c_frac), WIDTH));
    assign w_e   = WIDTH'(sat(64'((WIDTH+1)'(r_d) - (WIDTH+1)'(w_y)), WIDTH));
    assign w_upd = WIDTH'(sat(64'((WIDTH+3)'(r_w[r_idx]) + (WIDTH+3)'(w_prod_q2)), WIDTH));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state, handshakes and the shared-multiplier operand mux.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_a       = '0;
        w_b       = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = MAC;
            end
            MAC: begin
                w_a = r_w[r_idx];
                w_b = r_x[r_idx];
                if (r_idx == c_last_idx) w_next = ERR;
            end
            ERR: begin
                w_a    = step_size;
                w_b    = w_e;
                w_next = UPD;
            end
            UPD: begin
                w_a = r_mu_e;
                w_b = r_x[r_idx];
                if (r_idx == c_last_idx) w_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
            r_acc   <= '0;
            r_idx   <= '0;
            r_d     <= '0;
            r_adapt <= 1'b0;
            r_mu_e  <= '0;
            r_y     <= '0;
            r_err   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clear_weights) begin
                        for (int i = 0; i < TAPS; i++) r_w[i] <= '0;
                    end
                    if (in_valid) begin
                        r_x[0] <= din;
                        for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
                        r_d     <= desired;
                        r_adapt <= adapt_en;
                        r_acc   <= '0;
                        r_idx   <= '0;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + c_acc_w'(w_prod);
                    r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
                end
                ERR: begin
                    r_y    <= w_y;
                    r_err  <= w_e;
                    r_mu_e <= w_prod_q;
                    r_idx  <= '0;
                end
                UPD: begin
                    if (r_adapt) r_w[r_idx] <= w_upd;
                    r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign y_out   = r_y;
    assign err_out = r_err;

    for (genvar g = 0; g < TAPS; g++) begin : g_weights
        assign weights[g] = r_w[g];
    end

endmodule
`default_nettype wire
